// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU instruction sequencer: instruction classes, FSM states, field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  // Instruction class, taken from bits [21:20] of the instruction word
  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_JMP  = 2'b01,
    CLS_JCC  = 2'b10,
    CLS_HALT = 2'b11
  } cls_t;

  // Sequencer states; every instruction visits FETCH, DECODE, EXEC
  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  // Instruction word fields (16-bit immediate layout)
  localparam int F_CLS_HI = 21;
  localparam int F_CLS_LO = 20;
  localparam int F_FN_HI  = 19;
  localparam int F_FN_LO  = 16;
  localparam int F_IMM_HI = 15;
  localparam int F_IMM_LO = 0;

  // Within the 4-bit function field of a JCC: polarity bit and flag index
  localparam int FN_POL_BIT = 3;
  localparam int FN_IDX_HI  = 2;
  localparam int FN_IDX_LO  = 0;

endpackage

// File: rtl/alu_seq_cond.sv
// Conditional-jump evaluator: taken when flag_in[idx] equals the polarity bit; idx past FLAG_W never taken.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the sequencer in its EXEC cycle.
module alu_seq_cond
  import alu_seq_pkg::*;
#(
  parameter int FLAG_W = 5
) (
  input  logic [FLAG_W-1:0] flag_in,
  input  logic [3:0]        func,
  output logic              taken
);

  logic       hit;
  logic       sel_flag;
  logic [2:0] idx;

  assign idx = func[FN_IDX_HI:FN_IDX_LO];

  // Select the addressed flag; indices with no matching flag leave hit low so the jump is never taken
  always_comb begin
    hit      = 1'b0;
    sel_flag = 1'b0;
    for (int i = 0; i < FLAG_W && i < 8; i++) begin
      if (idx == 3'(i)) begin
        hit      = 1'b1;
        sel_flag = flag_in[i];
      end
    end
    taken = hit && (sel_flag == func[FN_POL_BIT]);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving the accumulator/ALU/flag datapath; optional JCC logic under `ALU_SEQ_JCC_EN.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC), plus one cycle per FETCH cycle with run low.
// Backpressure: run low holds the FSM in FETCH; once past FETCH an instruction always completes.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              run,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+5:0] prog_data,
  input  logic [FLAG_W-1:0] flag_in,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] arg2,
  output logic              A_ce,
  output logic              flagreg_ce,
  output logic              halted
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W+5:0] ir;
  cls_t              ir_cls;
  cls_t              dat_cls;
  logic              exec_alu;
  logic              taken;

  assign ir_cls  = cls_t'(ir[F_CLS_HI:F_CLS_LO]);
  assign dat_cls = cls_t'(prog_data[F_CLS_HI:F_CLS_LO]);

`ifdef ALU_SEQ_JCC_EN
  alu_seq_cond #(.FLAG_W(FLAG_W)) u_cond (
    .flag_in (flag_in),
    .func    (ir[F_FN_HI:F_FN_LO]),
    .taken   (taken)
  );
  logic unused_ir;
  assign unused_ir = ^ir;
`else
  // Without JCC support, class 10 falls through as a NOP and the flags are ignored
  assign taken = 1'b0;
  logic unused_in;
  assign unused_in = ^{flag_in, ir};
`endif

  // State, PC and IR; ALU operands are captured in DECODE so they are stable throughout EXEC and after it
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      opcode <= '0;
      arg2   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_DECODE) begin
        ir <= prog_data;
        if (dat_cls == CLS_ALU) begin
          opcode <= prog_data[F_FN_HI:F_FN_LO];
          arg2   <= prog_data[DATA_W-1:0];
        end
      end
    end
  end

  // Next-state and PC update; PC wraps naturally at 2^ADDR_W and jump targets are truncated to ADDR_W
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    exec_alu  = 1'b0;
    case (state)
      S_FETCH:  if (run) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + ADDR_W'(1);
        case (ir_cls)
          CLS_ALU:  exec_alu = 1'b1;
          CLS_JMP:  pc_nxt = ir[ADDR_W-1:0];
          CLS_JCC:  if (taken) pc_nxt = ir[ADDR_W-1:0];
          CLS_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
          default:  ;
        endcase
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  assign prog_addr = pc;
  // Enables are masked by reset so no commit can occur on an edge where reset is applied mid-EXEC
  assign A_ce       = exec_alu & RST_N;
  assign flagreg_ce = exec_alu & RST_N;
  // Halt is flagged from the HALT instruction's own EXEC cycle and stays until reset
  assign halted     = (state == S_HALT) || (state == S_EXEC && ir_cls == CLS_HALT);

endmodule
